// File: rtl/tick_sched_pkg.sv
// Shared types and default timing constants for the tick scheduler.
// Holds the arbiter state encoding and the divider defaults for a 100 MHz master clock.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

   localparam int DEF_PIX_DIV    = 4;
   localparam int DEF_FAST_DIV   = 131072;
   localparam int DEF_BULLET_DIV = 16777216;
   localparam int DEF_NREQ       = 4;
   localparam int DEF_WDOG_CYC   = 1024;

endpackage

// File: rtl/tick_div.sv
// Free-running modulo-DIV counter producing a registered one-cycle clock-enable strobe.
// Counting pauses and the strobe is forced low while i_run is 0.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   output logic o_ce
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;
   logic         r_ce;
   logic         w_wrap;

   assign w_wrap = (r_cnt == LAST);

   // The strobe rises in the cycle after the counter shows its last value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_ce  <= 1'b0;
      end else if (i_run) begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         r_ce  <= w_wrap;
      end else begin
         r_ce  <= 1'b0;
      end
   end

   assign o_ce = r_ce;

endmodule

// File: rtl/tick_scheduler.sv
// Timebase strobes plus a round-robin update-port arbiter opened once per fast tick.
// Define TICK_SCHED_WDOG_EN to build the WAIT-state watchdog (WDOG_CYC cycles).
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int PIX_DIV    = DEF_PIX_DIV,
   parameter int FAST_DIV   = DEF_FAST_DIV,
   parameter int BULLET_DIV = DEF_BULLET_DIV,
   parameter int NREQ       = DEF_NREQ,
   parameter int WDOG_CYC   = DEF_WDOG_CYC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            pix_ce,
   output logic            fast_ce,
   output logic            bullet_ce,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] done,
   output logic [NREQ-1:0] grant,
   output logic            round_act,
   output logic            overrun,
   output logic            wdog_to
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_t    r_state, w_next;
   logic [NREQ-1:0] r_grant, w_grant_nxt;
   logic [PW-1:0]   r_ptr, w_ptr_nxt, w_win_idx, w_scan_idx;
   logic            r_round_act, w_round_nxt;
   logic            r_overrun, w_overrun_set;
   logic            w_win_any, w_done_hit, w_wdog_hit, w_others, w_closing;
   logic            w_pix_ce, w_fast_ce, w_bullet_ce;

   tick_div #(.DIV(PIX_DIV)) u_pix_div (
      .i_clk(clk), .i_rst_n(rst), .i_run(run), .o_ce(w_pix_ce)
   );
   tick_div #(.DIV(FAST_DIV)) u_fast_div (
      .i_clk(clk), .i_rst_n(rst), .i_run(run), .o_ce(w_fast_ce)
   );
   tick_div #(.DIV(BULLET_DIV)) u_bullet_div (
      .i_clk(clk), .i_rst_n(rst), .i_run(run), .o_ce(w_bullet_ce)
   );

   // Scan backwards so the lane nearest after the pointer is the last to land.
   always_comb begin
      w_win_any  = 1'b0;
      w_win_idx  = r_ptr;
      w_scan_idx = '0;
      for (int j = NREQ; j >= 1; j--) begin
         w_scan_idx = PW'((int'(r_ptr) + j) % NREQ);
         if (req[w_scan_idx]) begin
            w_win_any = 1'b1;
            w_win_idx = w_scan_idx;
         end
      end
   end

   assign w_done_hit = (r_state != IDLE) && ((done & r_grant) != '0);
   assign w_others   = ((req & ~r_grant) != '0);

`ifdef TICK_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);

   logic [WW-1:0] r_wdog_cnt;
   logic          r_wdog_to;

   assign w_wdog_hit = (r_state == WAIT) && !w_done_hit && (r_wdog_cnt == WW'(WDOG_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wdog_cnt <= '0;
         r_wdog_to  <= 1'b0;
      end else begin
         if (r_state == WAIT && !w_done_hit && !w_wdog_hit) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
         end else begin
            r_wdog_cnt <= '0;
         end
         if (w_wdog_hit) begin
            r_wdog_to <= 1'b1;
         end
      end
   end

   assign wdog_to = r_wdog_to;
`else
   assign w_wdog_hit = 1'b0;
   assign wdog_to    = 1'b0;
`endif

   // A round ending in the same cycle as a fast tick is a clean hand-over, not an overrun.
   assign w_closing = ((r_state == IDLE) && r_round_act && !w_win_any) ||
                      ((w_done_hit || w_wdog_hit) && !w_others);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        if (r_round_act && w_win_any) w_next = GRANT;
         GRANT, WAIT: w_next = (w_done_hit || w_wdog_hit) ? IDLE : WAIT;
         default:     w_next = IDLE;
      endcase
   end

   always_comb begin
      w_grant_nxt   = r_grant;
      w_ptr_nxt     = r_ptr;
      w_round_nxt   = r_round_act;
      w_overrun_set = w_fast_ce && r_round_act && !w_closing;
      case (r_state)
         IDLE: begin
            if (r_round_act && w_win_any) begin
               w_grant_nxt = NREQ'(1) << w_win_idx;
               w_ptr_nxt   = w_win_idx;
            end else if (r_round_act) begin
               w_round_nxt = 1'b0;
            end
         end
         GRANT, WAIT: if (w_done_hit || w_wdog_hit) w_grant_nxt = '0;
         default:     w_grant_nxt = '0;
      endcase
      if (w_fast_ce) begin
         w_round_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant     <= '0;
         r_ptr       <= PW'(NREQ - 1);
         r_round_act <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_grant     <= w_grant_nxt;
         r_ptr       <= w_ptr_nxt;
         r_round_act <= w_round_nxt;
         r_overrun   <= r_overrun | w_overrun_set;
      end
   end

   assign pix_ce    = w_pix_ce;
   assign fast_ce   = w_fast_ce;
   assign bullet_ce = w_bullet_ce;
   assign grant     = r_grant;
   assign round_act = r_round_act;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized scoreboard bench for tick_scheduler with shortened dividers.
// Honours TICK_SCHED_WDOG_EN for the stalled-requester scenario.
module tb_tick_scheduler;

   localparam int NREQ = 4;
   localparam int PIX  = 4;
   localparam int FAST = 64;
   localparam int BUL  = 256;
   localparam int WD   = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] grant;
   logic            pix_ce, fast_ce, bullet_ce;
   logic            round_act, overrun, wdog_to;

   int              checks = 0;
   int              passes = 0;
   logic [NREQ-1:0] expQ[$];
   logic            stall = 1'b0;
   int              modelPtr = NREQ - 1;

   always #5 clk = ~clk;

   tick_scheduler #(
      .PIX_DIV(PIX), .FAST_DIV(FAST), .BULLET_DIV(BUL), .NREQ(NREQ), .WDOG_CYC(WD)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .pix_ce(pix_ce), .fast_ce(fast_ce), .bullet_ce(bullet_ce),
      .req(req), .done(done), .grant(grant),
      .round_act(round_act), .overrun(overrun), .wdog_to(wdog_to)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic failNow(input string name);
      checks++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic waitNeg();
      @(negedge clk);
      #2;
   endtask

   // Round-robin expectation: lanes in cyclic order starting just after the last winner.
   task automatic applyStimulus(input logic [NREQ-1:0] mask);
      int n;
      int last;
      n = 0;
      last = modelPtr;
      while ((round_act !== 1'b0 || grant !== '0 || req !== '0 || expQ.size() != 0) && n < 300) begin
         waitNeg();
         n++;
      end
      if (n >= 300) begin
         failNow("idle_before_stimulus");
         expQ.delete();
      end
      for (int j = 1; j <= NREQ; j++) begin
         int lane;
         lane = (modelPtr + j) % NREQ;
         if (mask[lane]) begin
            expQ.push_back(NREQ'(1) << lane);
            last = lane;
         end
      end
      modelPtr = last;
      req = mask;
   endtask

   task automatic waitRound();
      int n;
      n = 0;
      while ((expQ.size() != 0 || grant !== '0 || round_act !== 1'b0 || req !== '0) && n < 300) begin
         waitNeg();
         n++;
      end
      checks++;
      if (n < 300) passes++;
      else begin
         $display("[TB] FAIL round_complete: pending=%0d grant=%0h round_act=%0b, required all idle", expQ.size(), grant, round_act);
         req = '0;
         expQ.delete();
      end
   endtask

   task automatic waitGrant();
      int n;
      n = 0;
      while (grant === '0 && n < 300) begin
         waitNeg();
         n++;
      end
      if (n >= 300) failNow("grant_arrival");
   endtask

   // Strobe reference: count enabled clock edges since reset; strobe whenever that count divides evenly.
   initial begin
      int   k;
      logic rs, rn;
      k = 0;
      forever begin
         @(posedge clk);
         rs = rst;
         rn = run;
         #1;
         if (!rs) k = 0;
         else if (rn) k++;
         checkOutput("pix_ce",    32'(pix_ce),    32'(rs && rn && (k % PIX  == 0)));
         checkOutput("fast_ce",   32'(fast_ce),   32'(rs && rn && (k % FAST == 0)));
         checkOutput("bullet_ce", 32'(bullet_ce), 32'(rs && rn && (k % BUL  == 0)));
      end
   end

   // Monitor: each new grant is compared with the head of the scoreboard.
   initial begin
      logic [NREQ-1:0] prev;
      logic [NREQ-1:0] e;
      prev = '0;
      forever begin
         @(posedge clk);
         #1;
         if (grant !== prev && grant !== '0) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_grant", 32'(grant), 32'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("grant", 32'(grant), 32'(e));
            end
         end
         prev = grant;
      end
   end

   // Requester model: answers a grant after a random delay, drops its request on completion or revocation.
   initial begin
      int              cnt;
      bit              busy;
      logic [NREQ-1:0] held;
      cnt  = 0;
      busy = 0;
      held = '0;
      done = '0;
      forever begin
         @(negedge clk);
         done = NREQ'($urandom) & ~grant;
         if (grant === '0) begin
            if (busy) req = req & ~held;
            busy = 0;
         end else if (!busy) begin
            busy = 1;
            held = grant;
            cnt  = $urandom_range(1, 6);
         end else begin
            if (cnt > 0) cnt--;
            if (cnt == 0 && !stall) begin
               done = grant;
               req  = req & ~grant;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL sim_timeout: simulation did not finish");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      logic [NREQ-1:0] m;
      int              lane;
      int              n;
      rst = 1'b0;
      run = 1'b1;
      req = '0;
      repeat (3) waitNeg();
      checkOutput("rst_grant",     32'(grant),     32'(0));
      checkOutput("rst_round_act", 32'(round_act), 32'(0));
      checkOutput("rst_overrun",   32'(overrun),   32'(0));
      checkOutput("rst_wdog_to",   32'(wdog_to),   32'(0));
      rst = 1'b1;

      applyStimulus(4'b1111); waitRound();
      applyStimulus(4'b0010); waitRound();
      applyStimulus(4'b1010); waitRound();
      repeat (25) begin
         m = NREQ'($urandom);
         applyStimulus(m);
         waitRound();
      end
      checkOutput("overrun_idle", 32'(overrun), 32'(0));
      checkOutput("wdog_idle",    32'(wdog_to), 32'(0));

      applyStimulus(4'b0101);
      waitGrant();
      run = 1'b0;
      repeat (100) waitNeg();
      checkOutput("pause_grant",     32'(grant),       32'(0));
      checkOutput("pause_pending",   32'(expQ.size()), 32'(0));
      checkOutput("pause_round_act", 32'(round_act),   32'(0));
      run = 1'b1;
      waitRound();

      stall = 1'b1;
      lane  = $urandom_range(0, NREQ - 1);
      applyStimulus(NREQ'(1) << lane);
      waitGrant();
`ifdef TICK_SCHED_WDOG_EN
      repeat (40) waitNeg();
      checkOutput("wdog_grant_drop", 32'(grant),   32'(0));
      checkOutput("wdog_flag",       32'(wdog_to), 32'(1));
      checkOutput("wdog_no_overrun", 32'(overrun), 32'(0));
      stall = 1'b0;
      waitRound();
`else
      repeat (70) waitNeg();
      checkOutput("overrun_set",  32'(overrun), 32'(1));
      checkOutput("overrun_hold", 32'(grant),   32'(NREQ'(1) << lane));
      checkOutput("no_wdog",      32'(wdog_to), 32'(0));
      stall = 1'b0;
      waitRound();
      checkOutput("overrun_sticky", 32'(overrun), 32'(1));
`endif

      stall = 1'b1;
      lane  = $urandom_range(0, NREQ - 1);
      applyStimulus(NREQ'(1) << lane);
      waitGrant();
      n = 0;
      while (pix_ce !== 1'b1 && n < 20) begin
         waitNeg();
         n++;
      end
      checkOutput("pre_rst_pix",   32'(pix_ce), 32'(1));
      checkOutput("pre_rst_grant", 32'(grant),  32'(NREQ'(1) << lane));
      rst = 1'b0;
      #1;
      checkOutput("async_grant",     32'(grant),     32'(0));
      checkOutput("async_round_act", 32'(round_act), 32'(0));
      checkOutput("async_pix",       32'(pix_ce),    32'(0));
      checkOutput("async_overrun",   32'(overrun),   32'(0));
      stall = 1'b0;
      repeat (3) waitNeg();
      rst = 1'b1;
      modelPtr = NREQ - 1;
      repeat (5) waitNeg();
      checkOutput("post_rst_grant", 32'(grant), 32'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
